keypad_scan_encoder: RTL
========================

// Module: keypad_scan_encoder
// PURPOSE
//   Scans the 5x5 calculator key matrix, debounces presses and emits one newkey
//   pulse with a stable 5-bit keycode per physical press. It is the producer end
//   of the newkey/keycode interface consumed by Calculator_Core_Logic.
//   Keycode format: bit4=1 -> hex digit in [3:0]; bit4=0 -> function key.
// PARAMETERS
//   SCAN_DIV        1000  clock cycles each column is driven; sample on last cycle
//   DEBOUNCE_COUNT  8     consecutive identical samples to accept a press/release
// PORTS
//   clock    in   1  system clock
//   reset    in   1  synchronous, active-high
//   rows_n   in   5  matrix row inputs, active-low (pulled up), asynchronous
//   col_n    out  5  column drive, active-low, exactly one bit low at all times
//   newkey   out  1  one-cycle pulse: keycode valid for a new press
//   keycode  out  5  code of last accepted key, held until next press
//   key_down out  1  high from newkey cycle until release is debounced
// BEHAVIOUR
//   Reset: col_n=5'b11110 (col 0), newkey=0, keycode=0, key_down=0, state SCAN,
//     counters 0. Reset mid-operation aborts any press; no pulse is emitted.
//   rows_n passes a 2-flop synchronizer; all decisions use synchronized value.
//   Tick: dwell counter 0..SCAN_DIV-1; sample taken in cycle where count=SCAN_DIV-1.
//   Key map (row r, col c): r,c<4 -> {1'b1, 4*r+c} (digits 0-F);
//     r4c0=5'b00001 (square), r4c1=5'b00010 (CE), r4c2=5'b00100 (=),
//     r4c3=5'b01100 (AC), r0c4=5'b01001 (+), r1c4=5'b01010 (x);
//     r2c4, r3c4, r4c4 unmapped: never accepted.
//   FSM:
//   SCAN: drive col c. At tick: exactly one row low and (r,c) mapped -> latch
//     candidate r, cnt=1, DEBOUNCE (col held). Else c=c+1, wrap 4->0.
//   DEBOUNCE: at tick, same single row low -> cnt++; cnt reaching
//     DEBOUNCE_COUNT -> EMIT. Any other pattern -> SCAN, advance column.
//   EMIT: one cycle; newkey=1, keycode=map(r,c), key_down=1 -> HELD, cnt=0.
//   HELD: col held; other keys ignored. At tick: row r high -> cnt++ else cnt=0;
//     cnt reaching DEBOUNCE_COUNT -> key_down=0, SCAN at next column.
//   Latency: newkey asserts the cycle after the DEBOUNCE_COUNT-th consistent tick.
//   keycode updates only in EMIT; stable before, during and after newkey.
//   Held key: exactly one pulse, no auto-repeat. Multiple rows low in one
//     column (ghosting/multi-press) -> rejected, scanning continues.
//   Simultaneous keys in different columns: first column reached in scan wins.
//   newkey never asserts on two consecutive cycles; newkey=0 outside EMIT.
// TESTING (SCAN_DIV=4, DEBOUNCE_COUNT=3 unless stated)
//   1 Reset asserted mid-HELD, released -> col_n=11110, newkey=0, keycode=0,
//     key_down=0; held key must be released+repressed to pulse again.
//   2 Hold r1c1 200 cycles -> exactly one newkey, keycode=5'h15, key_down high
//     until 3 released ticks; col_n stays 5'b11101 while held.
//   3 r2c3 bounces low for 2 ticks then high -> no newkey; stable -> 5'h1B.
//   4 r4c2 -> 5'b00100; r0c4 -> 5'b01001; r4c3 -> 5'b01100; r3c4 -> no pulse.
//   5 r0c1+r2c1 together -> no pulse; r0c0 held then r1c2 pressed -> only 5'h10.
//   6 Integration with Calculator_Core_Logic: keys 2,5,+,6,B,= -> value=20'h90.

Source files
------------

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: 5x5 key matrix scanner/debouncer; ports clock, reset, rows_n(in,act-low), col_n(out,act-low), newkey/keycode/key_down(out)
module keypad_scan_encoder #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_COUNT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] rows_n,
  output logic [4:0] col_n,
  output logic       newkey,
  output logic [4:0] keycode,
  output logic       key_down
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HELD} state_t;
  state_t state_q, state_d;
  logic [4:0] sync1_q, sync2_q;
  logic [DW-1:0] div_q, div_d;
  logic [2:0] col_q, col_d, row_q, row_d, low_row, col_nx;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0] keycode_q, keycode_d, low;
  logic key_down_q, key_down_d, tick, one_low, done;
  logic [5:0] cand, held_map;
  function automatic logic [5:0] key_map(input logic [2:0] r, input logic [2:0] c);
    key_map = (r < 3'd4 && c < 3'd4) ? {2'b11, r[1:0], c[1:0]} :
              (r == 3'd4 && c == 3'd0) ? 6'b100001 :
              (r == 3'd4 && c == 3'd1) ? 6'b100010 :
              (r == 3'd4 && c == 3'd2) ? 6'b100100 :
              (r == 3'd4 && c == 3'd3) ? 6'b101100 :
              (r == 3'd0 && c == 3'd4) ? 6'b101001 :
              (r == 3'd1 && c == 3'd4) ? 6'b101010 : 6'b000000;
  endfunction
  always_comb begin
    tick = div_q == DW'(SCAN_DIV - 1);
    div_d = tick ? '0 : div_q + 1'b1;
    low = ~sync2_q;
    one_low = (low != 5'd0) && ((low & (low - 5'd1)) == 5'd0);
    low_row = 3'd0;
    for (int i = 0; i < 5; i++) if (low[i]) low_row = 3'(i);
    cand = key_map(low_row, col_q);
    held_map = key_map(row_q, col_q);
    col_nx = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
    cnt_inc = cnt_q + CW'(1);
    done = cnt_inc >= CW'(DEBOUNCE_COUNT);
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    cnt_d = cnt_q;
    keycode_d = keycode_q;
    key_down_d = key_down_q;
    case (state_q)
      SCAN: if (tick) begin
        if (one_low && cand[5]) begin
          row_d = low_row;
          cnt_d = CW'(1);
          state_d = (DEBOUNCE_COUNT <= 1) ? EMIT : DEBOUNCE;
          keycode_d = (DEBOUNCE_COUNT <= 1) ? cand[4:0] : keycode_q;
          key_down_d = (DEBOUNCE_COUNT <= 1) | key_down_q;
        end else col_d = col_nx;
      end
      DEBOUNCE: if (tick) begin
        if (one_low && low_row == row_q) begin
          cnt_d = cnt_inc;
          state_d = done ? EMIT : DEBOUNCE;
          keycode_d = done ? held_map[4:0] : keycode_q;
          key_down_d = done | key_down_q;
        end else begin
          state_d = SCAN;
          col_d = col_nx;
          cnt_d = '0;
        end
      end
      EMIT: begin
        state_d = HELD;
        cnt_d = '0;
      end
      default: if (tick) begin
        cnt_d = sync2_q[row_q] ? cnt_inc : '0;
        if (sync2_q[row_q] && done) begin
          key_down_d = 1'b0;
          state_d = SCAN;
          col_d = col_nx;
          cnt_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 5'h1F;
      sync2_q <= 5'h1F;
      div_q <= '0;
      state_q <= SCAN;
      col_q <= 3'd0;
      row_q <= 3'd0;
      cnt_q <= '0;
      keycode_q <= 5'd0;
      key_down_q <= 1'b0;
    end else begin
      sync1_q <= rows_n;
      sync2_q <= sync1_q;
      div_q <= div_d;
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
      keycode_q <= keycode_d;
      key_down_q <= key_down_d;
    end
  end
  assign col_n = ~(5'd1 << col_q);
  assign newkey = state_q == EMIT;
  assign keycode = keycode_q;
  assign key_down = key_down_q;
endmodule
